collision_detector: RTL and testbench
=====================================

# collision_detector

Per-pixel overlap detector that consumes the `drawingRequest` outputs of the bitmap blocks: player, blocks/bricks and up to NUM_ENEMIES enemies. It sits between the bitmap layer and the game-control logic. It raises one-cycle collision pulses on the first overlap in each frame. At every frame boundary it publishes a per-frame summary: edge code of the player-block contact, per-enemy hit vector and a saturating overlap-pixel count.

## Interface
- NUM_ENEMIES, 4, number of enemy drawing-request inputs
- PLAYER_W, 32, player sprite width in pixels
- PLAYER_H, 32, player sprite height in pixels
- EDGE_MARGIN, 4, pixel band at each sprite edge that classifies a contact edge
- PIPE_DELAY, 1, cycles by which pixelX/pixelY lag to align with bitmap drawingRequest
- COUNT_BITS, 12, width of overlap pixel counter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- startOfFrame  in  1  one-cycle pulse at first pixel of each frame
- pixelX, pixelY  in  11 each  current raster coordinate, same timing as fed to the bitmaps
- playerTLX, playerTLY  in  11 each  player top-left, stable during a frame
- playerDR  in  1  player bitmap drawingRequest
- blocksDR  in  1  blocks bitmap drawingRequest
- enemyDR  in  NUM_ENEMIES  enemy drawingRequests, bit i = enemy i
- playerBlockPulse  out  1  registered; first player∩blocks pixel of the frame
- playerEnemyPulse  out  1  registered; first player∩any-enemy pixel of the frame
- frameValid  out  1  one-cycle pulse when the summary outputs update
- hitEdgeCode  out  4  {Left,Top,Right,Bottom} of previous frame's player-block contacts
- enemyHitVec  out  NUM_ENEMIES  enemies that touched the player in previous frame
- overlapCount  out  COUNT_BITS  player∩blocks pixel count of previous frame, saturating

## Operation
- Alignment: pixelX/pixelY pass through a PIPE_DELAY-deep shift register (alignedX/Y). The DR inputs are used undelayed.
- States: IDLE (after reset) and SCAN. IDLE→SCAN on startOfFrame. No other transitions except reset→IDLE. In IDLE, DR inputs are ignored.
- In SCAN, per cycle:
  - pb = playerDR & blocksDR; pe = playerDR & enemyDR (vector).
  - If pb: accumulate edge bits into accEdge (OR) and increment accCount, saturating at 2^COUNT_BITS−1.
  - Edge bits: offX = alignedX − playerTLX, offY = alignedY − playerTLY (11-bit unsigned).
    - Left = offX < EDGE_MARGIN; Right = offX ≥ PLAYER_W−EDGE_MARGIN.
    - Top = offY < EDGE_MARGIN; Bottom = offY ≥ PLAYER_H−EDGE_MARGIN.
    - Corner pixels set two bits.
  - accEnemy |= pe.
  - First pb of the frame (flag pbSeen clear): set playerBlockPulse next cycle, set pbSeen. Same for pe≠0 with peSeen → playerEnemyPulse.
- startOfFrame while in SCAN:
  - Copy accEdge, accEnemy, accCount to the outputs; pulse frameValid.
  - Clear accumulators and the seen flags.
  - Overlap in the same cycle as startOfFrame belongs to the new frame: it is excluded from the published values, loads the cleared accumulators, and may raise a pulse.
- startOfFrame in IDLE: enter SCAN, no publish, frameValid stays 0.

## Timing
- Reset values: all outputs 0, state IDLE, accumulators 0, flags clear, delay line 0.
- Reset asserted mid-frame: immediate clear. The first frame after release is not published; the earliest frameValid is at the second startOfFrame.
- Pulse latency: 1 cycle after the overlapping input cycle. Width exactly 1 cycle. At most one pulse of each kind per frame.
- Summary latency: hitEdgeCode/enemyHitVec/overlapCount/frameValid change 1 cycle after the startOfFrame cycle. The summary holds until the next publish.
- Counter saturation: at max value it holds; no wrap.
- Offset underflow (DR asserted outside the player box) wraps modulo 2^11; Left/Top are then false and Right/Bottom true. This case is an integration error and is not flagged.

## Test plan
- Reset with reset=1, assert startOfFrame and DRs -> all outputs stay 0; release, first startOfFrame -> still no frameValid.
- Player at (100,200), blocksDR & playerDR for aligned pixels X=100..103, Y=210 -> playerBlockPulse once, 1 cycle after first overlap; next frame boundary gives hitEdgeCode=4'b1000, overlapCount=4, frameValid 1 cycle.
- Overlap at offset (0,0) and (31,31) in one frame -> hitEdgeCode=4'b1111.
- enemyDR=4'b0100 overlapping playerDR for 2 cycles, later 4'b0001 -> single playerEnemyPulse; published enemyHitVec=4'b0101.
- 5000 overlap pixels in one frame, COUNT_BITS=12 -> overlapCount=4095.
- Overlap in the same cycle as startOfFrame -> excluded from the published summary; counted in the following frame (overlapCount=1); playerBlockPulse fires for the new frame.

Source files
------------

// File: rtl/collision_detector.sv
// Per-pixel player/blocks/enemy overlap detector with first-hit pulses and a
// per-frame summary (contact edges, enemy hit vector, saturating pixel count).
module collision_detector #(
    parameter int NUM_ENEMIES = 4,
    parameter int PLAYER_W    = 32,
    parameter int PLAYER_H    = 32,
    parameter int EDGE_MARGIN = 4,
    parameter int PIPE_DELAY  = 1,
    parameter int COUNT_BITS  = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic [10:0]            playerTLX,
    input  logic [10:0]            playerTLY,
    input  logic                   playerDR,
    input  logic                   blocksDR,
    input  logic [NUM_ENEMIES-1:0] enemyDR,
    output logic                   playerBlockPulse,
    output logic                   playerEnemyPulse,
    output logic                   frameValid,
    output logic [3:0]             hitEdgeCode,
    output logic [NUM_ENEMIES-1:0] enemyHitVec,
    output logic [COUNT_BITS-1:0]  overlapCount
);

    localparam logic [10:0] EDGE_LO   = 11'(EDGE_MARGIN);
    localparam logic [10:0] RIGHT_TH  = 11'(PLAYER_W - EDGE_MARGIN);
    localparam logic [10:0] BOTTOM_TH = 11'(PLAYER_H - EDGE_MARGIN);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t state_q, state_d;

    logic [10:0] x_pipe_q [PIPE_DELAY];
    logic [10:0] x_pipe_d [PIPE_DELAY];
    logic [10:0] y_pipe_q [PIPE_DELAY];
    logic [10:0] y_pipe_d [PIPE_DELAY];

    logic [3:0]             acc_edge_q, acc_edge_d;
    logic [NUM_ENEMIES-1:0] acc_enemy_q, acc_enemy_d;
    logic [COUNT_BITS-1:0]  acc_count_q, acc_count_d;
    logic                   pb_seen_q, pb_seen_d;
    logic                   pe_seen_q, pe_seen_d;

    logic                   pb_pulse_q, pb_pulse_d;
    logic                   pe_pulse_q, pe_pulse_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [3:0]             hit_edge_q, hit_edge_d;
    logic [NUM_ENEMIES-1:0] enemy_hit_q, enemy_hit_d;
    logic [COUNT_BITS-1:0]  overlap_count_q, overlap_count_d;

    logic [10:0]            off_x, off_y;
    logic [3:0]             edge_bits;
    logic                   pb;
    logic [NUM_ENEMIES-1:0] pe;

    // Frame-local base values: cleared on a frame boundary so that an overlap
    // in the boundary cycle lands in the new frame.
    logic [3:0]             edge_base;
    logic [NUM_ENEMIES-1:0] enemy_base;
    logic [COUNT_BITS-1:0]  count_base;
    logic                   pb_seen_base;
    logic                   pe_seen_base;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign x_pipe_d[gi] = pixelX;
                assign y_pipe_d[gi] = pixelY;
            end else begin : g_tail
                assign x_pipe_d[gi] = x_pipe_q[gi-1];
                assign y_pipe_d[gi] = y_pipe_q[gi-1];
            end
        end
    endgenerate

    assign off_x     = x_pipe_q[PIPE_DELAY-1] - playerTLX;
    assign off_y     = y_pipe_q[PIPE_DELAY-1] - playerTLY;
    assign edge_bits = {off_x < EDGE_LO, off_y < EDGE_LO,
                        off_x >= RIGHT_TH, off_y >= BOTTOM_TH};
    assign pb        = playerDR & blocksDR;
    assign pe        = enemyDR & {NUM_ENEMIES{playerDR}};

    always_comb begin
        state_d         = state_q;
        acc_edge_d      = acc_edge_q;
        acc_enemy_d     = acc_enemy_q;
        acc_count_d     = acc_count_q;
        pb_seen_d       = pb_seen_q;
        pe_seen_d       = pe_seen_q;
        pb_pulse_d      = 1'b0;
        pe_pulse_d      = 1'b0;
        frame_valid_d   = 1'b0;
        hit_edge_d      = hit_edge_q;
        enemy_hit_d     = enemy_hit_q;
        overlap_count_d = overlap_count_q;
        edge_base       = acc_edge_q;
        enemy_base      = acc_enemy_q;
        count_base      = acc_count_q;
        pb_seen_base    = pb_seen_q;
        pe_seen_base    = pe_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (startOfFrame) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (startOfFrame) begin
                    frame_valid_d   = 1'b1;
                    hit_edge_d      = acc_edge_q;
                    enemy_hit_d     = acc_enemy_q;
                    overlap_count_d = acc_count_q;
                    edge_base       = '0;
                    enemy_base      = '0;
                    count_base      = '0;
                    pb_seen_base    = 1'b0;
                    pe_seen_base    = 1'b0;
                end
                acc_edge_d  = edge_base;
                acc_count_d = count_base;
                if (pb) begin
                    acc_edge_d  = edge_base | edge_bits;
                    acc_count_d = (count_base == COUNT_MAX) ? count_base
                                                            : count_base + COUNT_BITS'(1);
                end
                acc_enemy_d = enemy_base | pe;
                pb_pulse_d  = pb & ~pb_seen_base;
                pb_seen_d   = pb_seen_base | pb;
                pe_pulse_d  = (|pe) & ~pe_seen_base;
                pe_seen_d   = pe_seen_base | (|pe);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            acc_edge_q      <= '0;
            acc_enemy_q     <= '0;
            acc_count_q     <= '0;
            pb_seen_q       <= 1'b0;
            pe_seen_q       <= 1'b0;
            pb_pulse_q      <= 1'b0;
            pe_pulse_q      <= 1'b0;
            frame_valid_q   <= 1'b0;
            hit_edge_q      <= '0;
            enemy_hit_q     <= '0;
            overlap_count_q <= '0;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                x_pipe_q[i] <= '0;
                y_pipe_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            acc_edge_q      <= acc_edge_d;
            acc_enemy_q     <= acc_enemy_d;
            acc_count_q     <= acc_count_d;
            pb_seen_q       <= pb_seen_d;
            pe_seen_q       <= pe_seen_d;
            pb_pulse_q      <= pb_pulse_d;
            pe_pulse_q      <= pe_pulse_d;
            frame_valid_q   <= frame_valid_d;
            hit_edge_q      <= hit_edge_d;
            enemy_hit_q     <= enemy_hit_d;
            overlap_count_q <= overlap_count_d;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                x_pipe_q[i] <= x_pipe_d[i];
                y_pipe_q[i] <= y_pipe_d[i];
            end
        end
    end

    assign playerBlockPulse = pb_pulse_q;
    assign playerEnemyPulse = pe_pulse_q;
    assign frameValid       = frame_valid_q;
    assign hitEdgeCode      = hit_edge_q;
    assign enemyHitVec      = enemy_hit_q;
    assign overlapCount     = overlap_count_q;

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed frames with literal expectations plus
// randomized frames checked every cycle against a frame-level reference model.
module tb_collision_detector;

    localparam int NE = 4;
    localparam int PW = 32;
    localparam int PH = 32;
    localparam int EM = 4;
    localparam int PD = 1;
    localparam int CB = 12;
    localparam int CMAX = (1 << CB) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          sof;
    logic [10:0]   px, py, tlx, tly;
    logic          pdr, bdr;
    logic [NE-1:0] edr;
    logic          playerBlockPulse, playerEnemyPulse, frameValid;
    logic [3:0]    hitEdgeCode;
    logic [NE-1:0] enemyHitVec;
    logic [CB-1:0] overlapCount;

    collision_detector #(
        .NUM_ENEMIES(NE), .PLAYER_W(PW), .PLAYER_H(PH),
        .EDGE_MARGIN(EM), .PIPE_DELAY(PD), .COUNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof),
        .pixelX(px), .pixelY(py), .playerTLX(tlx), .playerTLY(tly),
        .playerDR(pdr), .blocksDR(bdr), .enemyDR(edr),
        .playerBlockPulse(playerBlockPulse), .playerEnemyPulse(playerEnemyPulse),
        .frameValid(frameValid), .hitEdgeCode(hitEdgeCode),
        .enemyHitVec(enemyHitVec), .overlapCount(overlapCount)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame-level bookkeeping with an unbounded pixel count
    // that is clamped only when a summary is published.
    bit          m_scan, m_pbseen, m_peseen;
    bit [3:0]    m_edge;
    bit [NE-1:0] m_enemy;
    int          m_cnt;
    int          hist_x[$];
    int          hist_y[$];
    bit          e_pbp, e_pep, e_fv;
    bit [3:0]    e_edge;
    bit [NE-1:0] e_ehv;
    int          e_cnt;
    bit          chk_en = 1'b0;
    int          pb_pulses, pe_pulses;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit [3:0] edge_of(int ax, int ay, int tx, int ty);
        int ox, oy;
        ox = (ax - tx) & 2047;
        oy = (ay - ty) & 2047;
        return {ox < EM, oy < EM, ox >= PW - EM, oy >= PH - EM};
    endfunction

    task automatic model_reset();
        m_scan = 0; m_pbseen = 0; m_peseen = 0; m_edge = 0; m_enemy = 0; m_cnt = 0;
        e_pbp = 0; e_pep = 0; e_fv = 0; e_edge = 0; e_ehv = 0; e_cnt = 0;
        hist_x.delete(); hist_y.delete();
        for (int i = 0; i < PD; i++) begin
            hist_x.push_back(0);
            hist_y.push_back(0);
        end
    endtask

    task automatic model_step();
        int ax, ay;
        bit pb;
        bit [NE-1:0] pe;
        if (reset) begin
            model_reset();
            return;
        end
        ax = hist_x.pop_front();
        ay = hist_y.pop_front();
        hist_x.push_back(int'(px));
        hist_y.push_back(int'(py));
        e_pbp = 0; e_pep = 0; e_fv = 0;
        if (!m_scan) begin
            if (sof) m_scan = 1;
            return;
        end
        if (sof) begin
            e_fv = 1; e_edge = m_edge; e_ehv = m_enemy;
            e_cnt = (m_cnt > CMAX) ? CMAX : m_cnt;
            m_edge = 0; m_enemy = 0; m_cnt = 0; m_pbseen = 0; m_peseen = 0;
        end
        pb = pdr && bdr;
        pe = pdr ? edr : '0;
        if (pb) begin
            m_edge |= edge_of(ax, ay, int'(tlx), int'(tly));
            m_cnt++;
            if (!m_pbseen) begin e_pbp = 1; m_pbseen = 1; end
        end
        m_enemy |= pe;
        if (pe != 0 && !m_peseen) begin e_pep = 1; m_peseen = 1; end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pb_pulse", playerBlockPulse, e_pbp);
            chk("pe_pulse", playerEnemyPulse, e_pep);
            chk("frame_valid", frameValid, e_fv);
            chk("edge_code", hitEdgeCode, e_edge);
            chk("enemy_vec", enemyHitVec, e_ehv);
            chk("overlap_cnt", overlapCount, e_cnt);
        end
    end

    task automatic cycle(bit s, bit p, bit b, bit [NE-1:0] e, int x, int y);
        sof = s; pdr = p; bdr = b; edr = e; px = 11'(x); py = 11'(y);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        if (playerBlockPulse) pb_pulses++;
        if (playerEnemyPulse) pe_pulses++;
        if (frameValid)
            $display("frame summary: edge=%b enemies=%b count=%0d",
                     hitEdgeCode, enemyHitVec, overlapCount);
    endtask

    initial begin
        int len;
        reset = 1'b1; sof = 0; pdr = 0; bdr = 0; edr = '0;
        px = 0; py = 0; tlx = 11'd100; tly = 11'd200;
        model_reset();
        chk_en = 1'b1;

        // Held in reset: frame starts and overlaps must have no effect.
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, '1, 100 + i, 200 + i);
        chk("rst_fv", frameValid, 0);
        chk("rst_pulse", playerBlockPulse, 0);
        reset = 1'b0;
        cycle(0, 1, 1, '1, 101, 201);
        chk("idle_ignores_dr", playerBlockPulse, 0);
        cycle(1, 0, 0, '0, 0, 0);
        chk("first_sof_no_fv", frameValid, 0);
        cycle(0, 0, 0, '0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0);
        chk("second_sof_fv", frameValid, 1);
        chk("empty_cnt", overlapCount, 0);

        // Left-edge overlap along row 210.
        pb_pulses = 0;
        cycle(0, 0, 0, '0, 100, 210);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, '0, 101 + i, 210);
            if (i == 0) chk("pb_latency", playerBlockPulse, 1);
            if (i == 1) chk("pb_width", playerBlockPulse, 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0);
        chk("a_fv", frameValid, 1);
        chk("a_edge", hitEdgeCode, 4'b1000);
        chk("a_cnt", overlapCount, 4);
        chk("a_pb_once", pb_pulses, 1);
        cycle(0, 0, 0, '0, 0, 0);
        chk("fv_width", frameValid, 0);
        chk("summary_hold", overlapCount, 4);

        // Opposite corners.
        cycle(0, 0, 0, '0, 100, 200);
        cycle(0, 1, 1, '0, 101, 200);
        cycle(0, 0, 0, '0, 131, 231);
        cycle(0, 1, 1, '0, 132, 231);
        cycle(1, 0, 0, '0, 0, 0);
        chk("b_edge", hitEdgeCode, 4'b1111);
        chk("b_cnt", overlapCount, 2);

        // Enemy hits.
        pe_pulses = 0;
        cycle(0, 1, 0, 4'b0100, 110, 210);
        chk("pe_latency", playerEnemyPulse, 1);
        cycle(0, 1, 0, 4'b0100, 111, 210);
        cycle(0, 0, 0, '0, 0, 0);
        cycle(0, 1, 0, 4'b0001, 112, 210);
        cycle(1, 0, 0, '0, 0, 0);
        chk("c_enemy", enemyHitVec, 4'b0101);
        chk("c_cnt", overlapCount, 0);
        chk("c_pe_once", pe_pulses, 1);

        // Saturation, then an overlap coinciding with the frame boundary.
        for (int i = 0; i < 5000; i++) cycle(0, 1, 1, '0, 111, 211);
        cycle(1, 1, 1, '0, 111, 211);
        chk("d_cnt_sat", overlapCount, CMAX);
        chk("sof_overlap_pulse", playerBlockPulse, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0);
        chk("e_cnt", overlapCount, 1);

        // Randomized frames with occasional mid-frame resets.
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(20, 400);
            tlx = 11'($urandom_range(0, 2000));
            tly = 11'($urandom_range(0, 2000));
            for (int c = 0; c < len; c++) begin
                int x, y;
                reset = ($urandom_range(0, 599) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    x = int'(tlx) + $urandom_range(0, 35);
                    y = int'(tly) + $urandom_range(0, 35);
                end else begin
                    x = $urandom_range(0, 2047);
                    y = $urandom_range(0, 2047);
                end
                cycle(c == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                      NE'($urandom & $urandom), x, y);
            end
            reset = 1'b0;
        end
        cycle(1, 0, 0, '0, 0, 0);
        cycle(0, 0, 0, '0, 0, 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
